// File: rtl/tblink_rpc_ctrl_cmd_if.sv
// Handshake bundle for the tblink RPC clock-control command issuer:
// host request, initiator byte stream, responder byte stream, completion.
interface tblink_rpc_ctrl_cmd_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [5:0] req_cnt;
    logic [7:0] i_dat;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] t_dat;
    logic       t_valid;
    logic       t_ready;
    logic       cpl_valid;
    logic       cpl_ready;
    logic       cpl_kind;
    logic [7:0] cpl_dat;
    logic       cpl_err;

    modport slave (
        input  req_valid, req_op, req_cnt,
        output req_ready,
        output i_dat, i_valid,
        input  i_ready,
        input  t_dat, t_valid,
        output t_ready,
        output cpl_valid, cpl_kind, cpl_dat, cpl_err,
        input  cpl_ready
    );

    modport master (
        output req_valid, req_op, req_cnt,
        input  req_ready,
        input  i_dat, i_valid,
        output i_ready,
        output t_dat, t_valid,
        input  t_ready,
        input  cpl_valid, cpl_kind, cpl_dat, cpl_err,
        output cpl_ready
    );
endinterface

// File: rtl/tblink_rpc_ctrl_cmd.sv
// Host-side command issuer for the tblink RPC clock-control channel.
// One command in flight: send command byte, parse reply, emit completion.
module tblink_rpc_ctrl_cmd #(
    parameter int                   TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = '1
) (
    input  logic                 uclock,
    input  logic                 reset,
    tblink_rpc_ctrl_cmd_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_HDR,
        WAIT_DAT,
        DONE
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_ONE = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    state_t               state;
    logic [1:0]           op;
    logic [TIMEOUT_W-1:0] wd;
    logic [TIMEOUT_W-1:0] wd_inc;
    logic                 wd_hit;
    logic                 beat;
    logic                 hdr_ok;

    assign beat   = bus.t_valid & bus.t_ready;
    assign wd_inc = (wd == WD_MAX) ? wd : wd + WD_ONE;
    // Fires on the cycle whose increment would reach TIMEOUT.
    assign wd_hit = (TIMEOUT != '0) && (wd_inc == TIMEOUT);
    assign hdr_ok = (op == 2'b01) && (bus.t_dat == 8'h01);

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op            <= 2'b00;
            wd            <= '0;
            bus.req_ready <= 1'b1;
            bus.i_valid   <= 1'b0;
            bus.i_dat     <= 8'h00;
            bus.t_ready   <= 1'b0;
            bus.cpl_valid <= 1'b0;
            bus.cpl_kind  <= 1'b0;
            bus.cpl_dat   <= 8'h00;
            bus.cpl_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        op            <= bus.req_op;
                        if (bus.req_op[1]) begin
                            state         <= DONE;
                            bus.cpl_valid <= 1'b1;
                            bus.cpl_err   <= 1'b1;
                            bus.cpl_kind  <= 1'b0;
                            bus.cpl_dat   <= 8'h00;
                        end else begin
                            state       <= SEND;
                            bus.i_valid <= 1'b1;
                            bus.i_dat   <= {bus.req_cnt, bus.req_op};
                        end
                    end
                end
                SEND: begin
                    if (bus.i_ready) begin
                        bus.i_valid <= 1'b0;
                        bus.t_ready <= 1'b1;
                        wd          <= '0;
                        state       <= WAIT_HDR;
                    end
                end
                WAIT_HDR: begin
                    if (beat) begin
                        wd <= '0;
                        if (op == 2'b00 && bus.t_dat == 8'h00) begin
                            state <= WAIT_DAT;
                        end else begin
                            state         <= DONE;
                            bus.t_ready   <= 1'b0;
                            bus.cpl_valid <= 1'b1;
                            bus.cpl_kind  <= op[0];
                            bus.cpl_dat   <= 8'h00;
                            bus.cpl_err   <= ~hdr_ok;
                        end
                    end else if (wd_hit) begin
                        state         <= DONE;
                        bus.t_ready   <= 1'b0;
                        bus.cpl_valid <= 1'b1;
                        bus.cpl_kind  <= op[0];
                        bus.cpl_dat   <= 8'h00;
                        bus.cpl_err   <= 1'b1;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                WAIT_DAT: begin
                    if (beat) begin
                        wd            <= '0;
                        state         <= DONE;
                        bus.t_ready   <= 1'b0;
                        bus.cpl_valid <= 1'b1;
                        bus.cpl_kind  <= 1'b0;
                        bus.cpl_dat   <= bus.t_dat;
                        bus.cpl_err   <= 1'b0;
                    end else if (wd_hit) begin
                        state         <= DONE;
                        bus.t_ready   <= 1'b0;
                        bus.cpl_valid <= 1'b1;
                        bus.cpl_kind  <= 1'b0;
                        bus.cpl_dat   <= 8'h00;
                        bus.cpl_err   <= 1'b1;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                DONE: begin
                    if (bus.cpl_ready) begin
                        state         <= IDLE;
                        bus.req_ready <= 1'b1;
                        bus.cpl_valid <= 1'b0;
                        bus.cpl_kind  <= 1'b0;
                        bus.cpl_dat   <= 8'h00;
                        bus.cpl_err   <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tblink_rpc_ctrl_cmd.sv
// Testbench for tblink_rpc_ctrl_cmd: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_tblink_rpc_ctrl_cmd;

    localparam int TMO = 8;

    logic uclock = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tblink_rpc_ctrl_cmd_if bus();

    tblink_rpc_ctrl_cmd #(
        .TIMEOUT_W(16),
        .TIMEOUT  (16'(TMO))
    ) dut (
        .uclock(uclock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 uclock = ~uclock;

    typedef struct {
        logic [7:0] cmd;
        bit         sends;
        logic       kind;
        logic [7:0] dat;
        logic       err;
        int         beats;
    } exp_t;

    // Expected outcome of one command, straight from the protocol rules.
    function automatic exp_t model(input int op, input int cnt,
                                   input int hdr, input int dat,
                                   input bit silent);
        exp_t e;
        e.cmd   = 8'(cnt * 4 + op);
        e.sends = (op < 2);
        e.kind  = (op == 1);
        e.dat   = 8'h00;
        e.err   = 1'b1;
        e.beats = 0;
        if (e.sends && !silent) begin
            e.beats = 1;
            if (op == 0 && hdr == 0) begin
                e.beats = 2;
                e.dat   = 8'(dat);
                e.err   = 1'b0;
            end else if (op == 1 && hdr == 1) begin
                e.err = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(negedge uclock);
    endtask

    task automatic run_txn(input int op, input int cnt, input int hdr,
                           input int dat, input bit silent, input bit early,
                           input int iwait, input int rdelay, input int cwait);
        exp_t e;
        int   n;
        e = model(op, cnt, hdr, dat, silent);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle got %b want 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = 2'(op);
        bus.req_cnt   = 6'(cnt);
        tick();
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_cnt   = 6'($urandom);
        if (!e.sends) begin
            checks++;
            if (bus.i_valid !== 1'b0 || bus.cpl_valid !== 1'b1) begin
                errors++;
                $display("FAIL reserved_cpl i_valid=%b cpl_valid=%b want 0/1",
                         bus.i_valid, bus.cpl_valid);
            end
        end else begin
            checks++;
            if (bus.i_valid !== 1'b1 || bus.i_dat !== e.cmd) begin
                errors++;
                $display("FAIL cmd_byte i_valid=%b i_dat=%h want 1/%h",
                         bus.i_valid, bus.i_dat, e.cmd);
            end
            bus.t_valid = early;
            bus.t_dat   = 8'(hdr);
            repeat (iwait) begin
                tick();
                checks++;
                if (bus.i_valid !== 1'b1 || bus.i_dat !== e.cmd ||
                    bus.t_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL send_hold i_valid=%b i_dat=%h t_ready=%b want 1/%h/0",
                             bus.i_valid, bus.i_dat, bus.t_ready, e.cmd);
                end
            end
            bus.i_ready = 1'b1;
            tick();
            bus.i_ready = 1'b0;
            checks++;
            if (bus.i_valid !== 1'b0 || bus.t_ready !== 1'b1) begin
                errors++;
                $display("FAIL wait_entry i_valid=%b t_ready=%b want 0/1",
                         bus.i_valid, bus.t_ready);
            end
            if (silent) begin
                n = 0;
                while (bus.cpl_valid !== 1'b1 && n < 4 * TMO) begin
                    tick();
                    n++;
                end
                checks++;
                if (n != TMO) begin
                    errors++;
                    $display("FAIL timeout_cycles got %0d want %0d", n, TMO);
                end
            end else begin
                if (!early) begin
                    repeat (rdelay) begin
                        tick();
                        checks++;
                        if (bus.t_ready !== 1'b1 || bus.cpl_valid !== 1'b0) begin
                            errors++;
                            $display("FAIL wait_idle t_ready=%b cpl_valid=%b want 1/0",
                                     bus.t_ready, bus.cpl_valid);
                        end
                    end
                end
                bus.t_valid = 1'b1;
                bus.t_dat   = 8'(hdr);
                tick();
                if (e.beats == 2) begin
                    bus.t_dat = 8'(dat);
                    tick();
                end
                bus.t_valid = 1'b0;
                checks++;
                if (bus.cpl_valid !== 1'b1 || bus.t_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL cpl_latency cpl_valid=%b t_ready=%b want 1/0",
                             bus.cpl_valid, bus.t_ready);
                end
            end
            checks++;
            if (bus.cpl_kind !== e.kind) begin
                errors++;
                $display("FAIL cpl_kind got %b want %b", bus.cpl_kind, e.kind);
            end
        end
        checks++;
        if (bus.cpl_dat !== e.dat || bus.cpl_err !== e.err) begin
            errors++;
            $display("FAIL cpl_fields dat=%h err=%b want %h/%b",
                     bus.cpl_dat, bus.cpl_err, e.dat, e.err);
        end
        repeat (cwait) begin
            tick();
            checks++;
            if (bus.cpl_valid !== 1'b1 || bus.cpl_dat !== e.dat ||
                bus.cpl_err !== e.err || bus.req_ready !== 1'b0 ||
                bus.i_valid !== 1'b0) begin
                errors++;
                $display("FAIL cpl_hold v=%b dat=%h err=%b rr=%b iv=%b want 1/%h/%b/0/0",
                         bus.cpl_valid, bus.cpl_dat, bus.cpl_err,
                         bus.req_ready, bus.i_valid, e.dat, e.err);
            end
        end
        bus.cpl_ready = 1'b1;
        tick();
        bus.cpl_ready = 1'b0;
        checks++;
        if (bus.cpl_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
            bus.cpl_err !== 1'b0) begin
            errors++;
            $display("FAIL cpl_release v=%b rr=%b err=%b want 0/1/0",
                     bus.cpl_valid, bus.req_ready, bus.cpl_err);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.i_valid !== 1'b0 ||
            bus.t_ready !== 1'b0 || bus.cpl_valid !== 1'b0 ||
            bus.i_dat !== 8'h00 || bus.cpl_dat !== 8'h00 ||
            bus.cpl_err !== 1'b0 || bus.cpl_kind !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rr=%b iv=%b tr=%b cv=%b idat=%h cdat=%h",
                     bus.req_ready, bus.i_valid, bus.t_ready,
                     bus.cpl_valid, bus.i_dat, bus.cpl_dat);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_advance();
        run_txn(1, 5, 8'h01, 0, 1'b0, 1'b0, 0, 0, 0);
        run_txn(1, 0, 8'h01, 0, 1'b0, 1'b0, 0, 2, 0);
    endtask

    task automatic test_capture();
        run_txn(0, 0, 8'h00, 8'hA5, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_bad_hdr();
        run_txn(1, 9, 8'h07, 0, 1'b0, 1'b0, 0, 1, 0);
        run_txn(0, 3, 8'h01, 0, 1'b0, 1'b0, 0, 0, 0);
        run_txn(1, 9, 8'h01, 0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reserved();
        run_txn(2, 7, 0, 0, 1'b0, 1'b0, 0, 0, 1);
        run_txn(3, 63, 0, 0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        run_txn(0, 1, 0, 0, 1'b1, 1'b0, 0, 0, 0);
        run_txn(1, 2, 0, 0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_stall();
        run_txn(1, 33, 8'h01, 0, 1'b0, 1'b0, 4, 0, 3);
        run_txn(0, 12, 8'h00, 8'h3C, 1'b0, 1'b1, 4, 0, 3);
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_cnt   = 6'd17;
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (bus.i_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_send got i_valid=%b want 1", bus.i_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.i_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset i_valid=%b req_ready=%b want 0/1",
                     bus.i_valid, bus.req_ready);
        end
        tick();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.cpl_valid !== 1'b0 ||
            bus.i_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset rr=%b cv=%b iv=%b want 1/0/0",
                     bus.req_ready, bus.cpl_valid, bus.i_valid);
        end
        run_txn(0, 4, 8'h00, 8'h5A, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            int op, cnt, hdr, dat, r;
            bit silent, early;
            op     = $urandom_range(0, 3);
            cnt    = $urandom_range(0, 63);
            dat    = $urandom_range(0, 255);
            r      = $urandom_range(0, 9);
            silent = (r == 0);
            early  = !silent && ($urandom_range(0, 3) == 0);
            hdr    = (op == 0) ? 0 : 1;
            if (r >= 8) hdr = (hdr + $urandom_range(1, 255)) % 256;
            run_txn(op, cnt, hdr, dat, silent, early,
                    $urandom_range(0, 3), $urandom_range(0, 5),
                    $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            run_txn(k % 2, k + 1, k % 2, 8'hC0 + k, 1'b0, 1'b0, 0, 0, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_cnt   = 6'd0;
        bus.i_ready   = 1'b0;
        bus.t_valid   = 1'b0;
        bus.t_dat     = 8'h00;
        bus.cpl_ready = 1'b0;
        test_reset();
        test_advance();
        test_capture();
        test_bad_hdr();
        test_reserved();
        test_timeout();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
